// File: rtl/divider_pkg.sv
// Shared types and constants for the RV32M iterative divider.
package div_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned DIV_STEPS     = 32;
  localparam int unsigned CNT_W         = 5;
  localparam int unsigned CTRL_UNSIGNED = 0;
  localparam int unsigned CTRL_REM      = 1;

  localparam logic [XLEN-1:0] DIV0_Q       = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] OVF_DIVIDEND = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  // Two's-complement magnitude when neg is set, passthrough otherwise.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic neg);
    return neg ? XLEN'(-x) : x;
  endfunction

endpackage

// File: rtl/divider_if.sv
// Issue/result bundle between the execute stage and the divider.
interface divider_if;
  import div_pkg::*;

  logic            start;
  logic            flush;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [1:0]      ctrl;
  logic            busy;
  logic            valid;
  logic [XLEN-1:0] y;

  modport master (output start, flush, a, b, ctrl, input busy, valid, y);
  modport slave  (input start, flush, a, b, ctrl, output busy, valid, y);

endinterface

// File: rtl/divider_step.sv
// One combinational restoring-division step: shift {r,q} left, subtract divisor if it fits.
module divider_step
  import div_pkg::*;
(
  input  logic [XLEN:0]   r,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] d,
  output logic [XLEN:0]   r_next,
  output logic [XLEN-1:0] q_next
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;

  always_comb begin
    shifted = {r, q[XLEN-1]};
    diff    = shifted - {2'b00, d};
    r_next  = (XLEN+1)'(shifted);
    q_next  = {q[XLEN-2:0], 1'b0};
    if (shifted >= {2'b00, d}) begin
      r_next    = (XLEN+1)'(diff);
      q_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/divider.sv
// Iterative radix-2 DIV/DIVU/REM/REMU unit with start/valid handshake and flush.
// Build option: DIVIDER_EARLY_OUT_EN lets divide-by-zero and signed overflow skip CALC.
module divider
  import div_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  divider_if.slave  bus
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN:0]    r;
  logic [XLEN-1:0]  q;
  logic [XLEN-1:0]  d;
  logic [XLEN-1:0]  a_q;
  logic             sign_q;
  logic             sign_r;
  logic             rem_op;
  logic             div0;
  logic             ovf;

  logic [XLEN:0]    r_nxt;
  logic [XLEN-1:0]  q_nxt;
  logic             is_signed_c;
  logic             div0_c;
  logic             ovf_c;
  logic [XLEN-1:0]  res_c;

  divider_step u_step (
    .r      (r),
    .q      (q),
    .d      (d),
    .r_next (r_nxt),
    .q_next (q_nxt)
  );

  // Operand classification at the accept edge.
  always_comb begin
    is_signed_c = ~bus.ctrl[CTRL_UNSIGNED];
    div0_c      = (bus.b == '0);
    ovf_c       = is_signed_c && (bus.a == OVF_DIVIDEND) && (bus.b == '1);
  end

  // Final result: RISC-V special cases take priority over the sign fix-up.
  always_comb begin
    res_c = '0;
    if (div0) begin
      res_c = rem_op ? a_q : DIV0_Q;
    end else if (ovf) begin
      res_c = rem_op ? '0 : OVF_DIVIDEND;
    end else if (rem_op) begin
      res_c = sign_r ? XLEN'(-r[XLEN-1:0]) : r[XLEN-1:0];
    end else begin
      res_c = sign_q ? XLEN'(-q) : q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      r         <= '0;
      q         <= '0;
      d         <= '0;
      a_q       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      rem_op    <= 1'b0;
      div0      <= 1'b0;
      ovf       <= 1'b0;
      bus.busy  <= 1'b0;
      bus.valid <= 1'b0;
      bus.y     <= '0;
    end else begin
      bus.valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            q        <= mag(bus.a, is_signed_c & bus.a[XLEN-1]);
            d        <= mag(bus.b, is_signed_c & bus.b[XLEN-1]);
            r        <= '0;
            a_q      <= bus.a;
            cnt      <= CNT_W'(DIV_STEPS - 1);
            sign_q   <= is_signed_c & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
            sign_r   <= is_signed_c & bus.a[XLEN-1];
            rem_op   <= bus.ctrl[CTRL_REM];
            div0     <= div0_c;
            ovf      <= ovf_c;
            bus.busy <= 1'b1;
`ifdef DIVIDER_EARLY_OUT_EN
            state    <= (div0_c || ovf_c) ? FIX : CALC;
`else
            state    <= CALC;
`endif
          end
        end
        CALC: begin
          if (bus.flush) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            r   <= r_nxt;
            q   <= q_nxt;
            cnt <= cnt - CNT_W'(1);
            if (cnt == '0) state <= FIX;
          end
        end
        FIX: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          if (!bus.flush) begin
            bus.y     <= res_c;
            bus.valid <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
